// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the Mini-MIPS fetch stage.
// It adds stall, branch/jump redirect, exception entry, ERET return,
// halt/resume and misaligned-target trapping to a plain PC register.
//
// Ports:
//   clk             rising-edge system clock
//   reset           synchronous, active-high; overrides every other input
//   stall           hold pc this cycle (RUN only)
//   redirect_valid  taken branch/jump; redirect_target is the destination
//   exception       enter the exception vector, saving pc into epc
//   eret            return from exception (pc <= epc)
//   halt            halt instruction retiring at the current pc
//   resume          leave the HALTED state
//   pc              registered fetch address
//   pc_plus_step    combinational pc + STEP, modulo 2^WIDTH
//   pc_valid        registered; 1 exactly while state is RUN
//   epc             registered exception return address
//   misaligned      registered one-cycle pulse on a trapped misaligned redirect
//   state           registered FSM state: 0 BOOT, 1 RUN, 2 HALTED
module pc_sequencer #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h00400000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h80000180,
  parameter int unsigned       STEP         = 4,
  parameter int unsigned       ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exception,
  input  logic             eret,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             misaligned,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Mask of the low address bits that must be zero; all-zero when
  // ALIGN_BITS is 0, which disables the check.
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic             pc_valid_q;
  logic             misaligned_q;
  logic             target_misaligned;

  assign pc_plus_step      = pc_q + WIDTH'(STEP);
  assign target_misaligned = |(redirect_target & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      pc_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          // Strict priority: only the highest true condition takes effect.
          if (exception) begin
            epc_q <= pc_q;
            pc_q  <= EXC_VECTOR;
          end else if (eret) begin
            pc_q <= epc_q;
          end else if (redirect_valid && target_misaligned) begin
            epc_q        <= pc_q;
            pc_q         <= EXC_VECTOR;
            misaligned_q <= 1'b1;
          end else if (redirect_valid) begin
            pc_q <= redirect_target;
          end else if (halt) begin
            pc_q       <= pc_plus_step;
            state_q    <= HALTED;
            pc_valid_q <= 1'b0;
          end else if (!stall) begin
            pc_q <= pc_plus_step;
          end
        end
        HALTED: begin
          if (exception) begin
            epc_q      <= pc_q;
            pc_q       <= EXC_VECTOR;
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end else if (resume) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover through BOOT.
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign pc_valid   = pc_valid_q;
  assign misaligned = misaligned_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: a default 32-bit instance and an
// 8-bit instance exercising pc wrap-around and reset from HALTED.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance stimulus
  logic        reset, stall, redirect_valid, exception, eret, halt, resume;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_plus_step, epc;
  logic        pc_valid, misaligned;
  logic [1:0]  state;

  // 8-bit instance stimulus
  logic        reset8, stall8, redirect_valid8, exception8, eret8, halt8, resume8;
  logic [7:0]  redirect_target8;
  logic [7:0]  pc8, pc_plus_step8, epc8;
  logic        pc_valid8, misaligned8;
  logic [1:0]  state8;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer u_dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exception       (exception),
    .eret            (eret),
    .halt            (halt),
    .resume          (resume),
    .pc              (pc),
    .pc_plus_step    (pc_plus_step),
    .pc_valid        (pc_valid),
    .epc             (epc),
    .misaligned      (misaligned),
    .state           (state)
  );

  pc_sequencer #(
    .WIDTH        (8),
    .RESET_VECTOR (8'hF8),
    .EXC_VECTOR   (8'h80),
    .STEP         (4),
    .ALIGN_BITS   (2)
  ) u_small (
    .clk             (clk),
    .reset           (reset8),
    .stall           (stall8),
    .redirect_valid  (redirect_valid8),
    .redirect_target (redirect_target8),
    .exception       (exception8),
    .eret            (eret8),
    .halt            (halt8),
    .resume          (resume8),
    .pc              (pc8),
    .pc_plus_step    (pc_plus_step8),
    .pc_valid        (pc_valid8),
    .epc             (epc8),
    .misaligned      (misaligned8),
    .state           (state8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_state(input string tag, input logic [31:0] exp_pc,
                           input logic exp_valid, input logic [1:0] exp_state);
    check({tag, ".pc"}, pc, exp_pc);
    check({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, exp_valid});
    check({tag, ".state"}, {30'd0, state}, {30'd0, exp_state});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exception = 1'b0; eret = 1'b0; halt = 1'b0; resume = 1'b0;
    reset8 = 1'b1; stall8 = 1'b0; redirect_valid8 = 1'b0; redirect_target8 = '0;
    exception8 = 1'b0; eret8 = 1'b0; halt8 = 1'b0; resume8 = 1'b0;

    // Reset for two cycles
    tick(); tick();
    run_state("reset", 32'h00400000, 1'b0, 2'd0);
    check("reset.epc", epc, 32'h0);
    check("reset.misaligned", {31'd0, misaligned}, 32'h0);

    // Release: BOOT cycle, then RUN fetching RESET_VECTOR
    reset = 1'b0;
    tick();
    run_state("boot_exit", 32'h00400000, 1'b1, 2'd1);
    check("boot_exit.pc_plus_step", pc_plus_step, 32'h00400004);
    tick(); check("seq1", pc, 32'h00400004);
    tick(); check("seq2", pc, 32'h00400008);
    tick(); tick(); check("seq4", pc, 32'h00400010);

    // Stall 3 cycles, then redirect beats stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", pc, 32'h00400010);
    end
    redirect_valid = 1'b1; redirect_target = 32'h00400100;
    tick(); check("redirect_over_stall", pc, 32'h00400100);
    stall = 1'b0;

    // Go to 0x00400020, then exception beats redirect
    redirect_target = 32'h00400020;
    tick(); check("redirect_20", pc, 32'h00400020);
    exception = 1'b1; redirect_target = 32'h00400100;
    tick();
    check("exc.pc", pc, 32'h80000180);
    check("exc.epc", epc, 32'h00400020);
    check("exc.misaligned", {31'd0, misaligned}, 32'h0);
    exception = 1'b0; redirect_valid = 1'b0;
    eret = 1'b1;
    tick(); check("eret.pc", pc, 32'h00400020);
    eret = 1'b0;
    tick(); check("after_eret", pc, 32'h00400024);

    // Misaligned redirect traps
    redirect_valid = 1'b1; redirect_target = 32'h00400102;
    tick();
    check("mis.pc", pc, 32'h80000180);
    check("mis.epc", epc, 32'h00400024);
    check("mis.pulse", {31'd0, misaligned}, 32'h1);
    redirect_valid = 1'b0;
    tick();
    check("mis.clear", {31'd0, misaligned}, 32'h0);
    check("mis.next", pc, 32'h80000184);

    // eret beats redirect
    eret = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h00400100;
    tick(); check("eret_over_redirect", pc, 32'h00400024);
    eret = 1'b0;

    // Halt at 0x00400030
    redirect_target = 32'h00400030;
    tick(); check("redirect_30", pc, 32'h00400030);
    redirect_valid = 1'b0; halt = 1'b1;
    tick(); run_state("halt", 32'h00400034, 1'b0, 2'd2);
    halt = 1'b0;
    redirect_target = 32'h00400200;
    for (int i = 0; i < 5; i++) begin
      stall = i[0]; redirect_valid = ~i[0]; eret = i[1]; halt = i[0];
      tick(); run_state("halted_hold", 32'h00400034, 1'b0, 2'd2);
    end
    stall = 1'b0; redirect_valid = 1'b0; eret = 1'b0; halt = 1'b0;
    check("halted.epc", epc, 32'h00400024);
    resume = 1'b1;
    tick(); run_state("resume", 32'h00400034, 1'b1, 2'd1);
    resume = 1'b0;
    tick(); check("resume_step", pc, 32'h00400038);

    // Exception leaves HALTED
    halt = 1'b1;
    tick(); run_state("halt2", 32'h0040003C, 1'b0, 2'd2);
    halt = 1'b0; exception = 1'b1;
    tick();
    run_state("halt_exc", 32'h80000180, 1'b1, 2'd1);
    check("halt_exc.epc", epc, 32'h0040003C);
    exception = 1'b0;

    // Reset mid-stall
    stall = 1'b1; reset = 1'b1;
    tick(); run_state("reset_mid_stall", 32'h00400000, 1'b0, 2'd0);
    check("reset_mid_stall.epc", epc, 32'h0);
    stall = 1'b0;

    // 8-bit instance: wrap-around and reset from HALTED
    reset8 = 1'b0;
    tick();
    check("w8.pc0", {24'd0, pc8}, 32'hF8);
    check("w8.valid0", {31'd0, pc_valid8}, 32'h1);
    tick();
    check("w8.pc1", {24'd0, pc8}, 32'hFC);
    check("w8.pps", {24'd0, pc_plus_step8}, 32'h00);
    tick(); check("w8.pc2", {24'd0, pc8}, 32'h00);
    tick(); check("w8.pc3", {24'd0, pc8}, 32'h04);
    halt8 = 1'b1;
    tick();
    check("w8.halt_pc", {24'd0, pc8}, 32'h08);
    check("w8.halt_state", {30'd0, state8}, 32'h2);
    halt8 = 1'b0; reset8 = 1'b1;
    tick();
    check("w8.reset_state", {30'd0, state8}, 32'h0);
    check("w8.reset_pc", {24'd0, pc8}, 32'hF8);
    check("w8.reset_valid", {31'd0, pc_valid8}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
